branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the ID stage of the 5-stage RV32 pipeline. It accepts one conditional branch at a time and waits out operand hazards. It drives the shared `branch_comparator` operands, derives the taken decision for all six B-type funct3 codes from the comparator flags, and issues a redirect on mispredict. It also owns the 2-bit branch history table (BHT) that the IF stage reads for its prediction.

## Interface
Parameters:
- `IDX_W`, 4: BHT index width; the table has 2^IDX_W entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  IF-stage PC used for the BHT lookup.
- `if_pred_taken`  out  1  combinational prediction: bit 1 of `bht[if_pc[IDX_W+1:2]]`.
- `br_valid`  in  1  ID holds a conditional branch.
- `br_ready`  out  1  1 only in IDLE.
- `br_funct3`  in  3  branch funct3.
- `br_pc`  in  32  branch PC.
- `br_imm`  in  32  sign-extended B-immediate.
- `br_pred`  in  1  prediction the branch was fetched with.
- `rs1_val`, `rs2_val`  in  32 each  forwarded operands.
- `opnd_hazard`  in  1  operands not yet valid (load-use).
- `kill`  in  1  flush from an older instruction; aborts the pending branch.
- `cmp_a`, `cmp_b`  out  32 each  registered operands to `branch_comparator`.
- `cmp_neq`, `cmp_lt`  in  1 each  comparator flags; `cmp_lt` is an unsigned compare.
- `res_valid`  out  1  one-cycle resolution pulse.
- `res_taken`  out  1  resolved direction.
- `redirect_valid`  out  1  `res_valid & (res_taken != pred)`.
- `redirect_pc`  out  32  taken → `pc+imm`; not taken → `pc+4`. Mod 2^32.
- `illegal_br`  out  1  pulses with `res_valid` for funct3 010 or 011.
- `br_cnt`, `mispred_cnt`  out  32 each  resolution and redirect counters; both wrap.

## Operation
- FSM states: IDLE, WAIT, RESOLVE.
- IDLE:
  - On `br_valid & br_ready`, latch funct3, pc, imm and pred.
  - If `opnd_hazard` = 0, latch `rs1_val`/`rs2_val` into `cmp_a`/`cmp_b` and go to RESOLVE.
  - Otherwise go to WAIT.
- WAIT: each cycle with `opnd_hazard` = 0, latch the operands and go to RESOLVE. Otherwise stay in WAIT.
- RESOLVE: produce outputs from the comparator flags, update the BHT and counters, then return to IDLE.
- Decision rules:
  - `eq = !cmp_neq`.
  - Unsigned `ltu = cmp_lt`.
  - Signed `lts = (a[31]^b[31]) ? a[31] : cmp_lt`.
  - BEQ → eq; BNE → !eq; BLT → lts; BGE → !lts; BLTU → ltu; BGEU → !ltu.
  - funct3 010/011: not taken, `illegal_br` = 1, no BHT update.
- BHT: 2-bit saturating counters. Taken increments, saturating at 11. Not taken decrements, saturating at 00.
- `kill` in WAIT or RESOLVE: next state is IDLE, and all RESOLVE outputs and updates are gated off in that cycle. `kill` in IDLE blocks acceptance that cycle (`br_ready` = 0).
- Simultaneous IF read and RESOLVE write to the same BHT index: the read returns the old value.

## Timing
- Reset values:
  - State IDLE; every BHT entry 01 (weakly not taken).
  - `cmp_a`, `cmp_b`, `br_cnt`, `mispred_cnt` = 0.
  - All pulse outputs and `redirect_pc` = 0.
  - `br_ready` = 1 after reset unless `kill` is asserted.
- Latency: acceptance at cycle T with no hazard gives `res_valid` at T+1. Each hazard cycle adds 1.
- Throughput: at most one branch per 2 cycles.
- The resolution outputs are combinational from RESOLVE state plus the registered operands and flags. They are valid for exactly one cycle.
- BHT write and counter increments take effect at the end of the RESOLVE cycle.
- `rst` mid-operation discards the pending branch without updating the BHT or counters.

## Structure
- Package `branch_pkg` holds:
  - funct3 constants BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111;
  - the state encoding (IDLE, WAIT, RESOLVE);
  - the BHT reset value 2'b01.
- Sub-module `branch_bht` (parameter `IDX_W`) has a combinational read port and a synchronous saturating-update port.
- `branch_comparator` is instantiated by the parent stage, not inside this block.

## Test plan
- BEQ, rs1=rs2=5, pred=0, pc=0x100, imm=0x20 → `res_valid` at T+1, taken=1, redirect to 0x120, BHT[0] goes 01→10, `mispred_cnt`=1.
- BLT, rs1=0xFFFFFFFF, rs2=1 → `lts`=1, taken. The same operands with BLTU → not taken, redirect_pc = pc+4 when pred=1.
- BNE with `opnd_hazard` high for 3 cycles → `br_ready`=0 throughout, `res_valid` at T+4 using the operands sampled on the last cycle.
- Four taken BGEs at the same index → counter saturates at 11. Then one not-taken → 10, and `if_pred_taken` stays 1.
- `kill` asserted in RESOLVE → `res_valid`=0, `redirect_valid`=0, no BHT or counter change, IDLE next cycle.
- funct3=010 → `res_valid`=1, `illegal_br`=1, not taken, BHT unchanged.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolution controller:
// funct3 codes, FSM state encoding, BHT reset value and counter helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESOLVE = 2'b10
    } br_state_e;

    // Weakly not taken.
    localparam logic [1:0] BHT_RESET = 2'b01;

    // Two-bit saturating counter step.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch request / resolution bundle between the ID stage and branch_ctrl.
interface branch_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        br_pred;

    logic        res_valid;
    logic        res_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_br;

    // ID stage side: issues branches, consumes resolutions.
    modport master (
        output br_valid, br_funct3, br_pc, br_imm, br_pred,
        input  br_ready, res_valid, res_taken, redirect_valid, redirect_pc, illegal_br
    );

    // Controller side.
    modport slave (
        input  br_valid, br_funct3, br_pc, br_imm, br_pred,
        output br_ready, res_valid, res_taken, redirect_valid, redirect_pc, illegal_br
    );
endinterface

// File: rtl/branch_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters with a
// combinational read port (old value on same-cycle write) and a
// synchronous update port.
module branch_bht
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] ctr_r [ENTRIES];

    assign rd_ctr = ctr_r[rd_idx];

    // Counter array: reset to weakly not taken, saturating update on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= BHT_RESET;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= bht_next(ctr_r[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller. Accepts one conditional branch,
// waits out operand hazards, drives the external comparator operands,
// decides the direction from the comparator flags and raises a redirect on
// mispredict. Owns the BHT used by IF for its prediction.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   if_pc,
    output logic          if_pred_taken,
    branch_ctrl_if.slave  br,
    input  logic [31:0]   rs1_val,
    input  logic [31:0]   rs2_val,
    input  logic          opnd_hazard,
    input  logic          kill,
    output logic [31:0]   cmp_a,
    output logic [31:0]   cmp_b,
    input  logic          cmp_neq,
    input  logic          cmp_lt,
    output logic [31:0]   br_cnt,
    output logic [31:0]   mispred_cnt
);

    br_state_e   state_r;
    br_state_e   state_nxt_s;
    logic        accept_s;
    logic        opnd_load_s;
    logic        active_s;

    logic [2:0]  funct3_r;
    logic [31:0] pc_r;
    logic [31:0] imm_r;
    logic        pred_r;
    logic [31:0] cmp_a_r;
    logic [31:0] cmp_b_r;
    logic [31:0] br_cnt_r;
    logic [31:0] mispred_cnt_r;

    logic        eq_s;
    logic        lts_s;
    logic        taken_s;
    logic        illegal_s;
    logic [1:0]  rd_ctr_s;

    // Only the index bits of the IF PC address the table.
    logic        unused_if_pc_s;
    assign unused_if_pc_s = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign br.br_ready = (state_r == IDLE) && !kill;
    assign cmp_a       = cmp_a_r;
    assign cmp_b       = cmp_b_r;
    assign br_cnt      = br_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic with acceptance, operand-latch and resolve strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        opnd_load_s = 1'b0;
        active_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (br.br_valid && !kill) begin
                    accept_s = 1'b1;
                    if (!opnd_hazard) begin
                        opnd_load_s = 1'b1;
                        state_nxt_s = RESOLVE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (kill) begin
                    state_nxt_s = IDLE;
                end else if (!opnd_hazard) begin
                    opnd_load_s = 1'b1;
                    state_nxt_s = RESOLVE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESOLVE: begin
                state_nxt_s = IDLE;
                // A kill or reset in this cycle discards the branch entirely.
                if (!kill && !rst) begin
                    active_s = 1'b1;
                end else begin
                    active_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Direction decision from comparator flags; lt is unsigned, the signed
    // result is fixed up from the operand sign bits.
    always_comb begin
        eq_s      = !cmp_neq;
        lts_s     = (cmp_a_r[31] ^ cmp_b_r[31]) ? cmp_a_r[31] : cmp_lt;
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (funct3_r)
            F3_BEQ:  taken_s = eq_s;
            F3_BNE:  taken_s = !eq_s;
            F3_BLT:  taken_s = lts_s;
            F3_BGE:  taken_s = !lts_s;
            F3_BLTU: taken_s = cmp_lt;
            F3_BGEU: taken_s = !cmp_lt;
            default: begin
                taken_s   = 1'b0;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Resolution outputs, valid only during an un-killed RESOLVE cycle.
    always_comb begin
        br.res_valid      = active_s;
        br.res_taken      = active_s && taken_s;
        br.redirect_valid = active_s && (taken_s != pred_r);
        br.illegal_br     = active_s && illegal_s;
        if (active_s) begin
            br.redirect_pc = taken_s ? (pc_r + imm_r) : (pc_r + 32'd4);
        end else begin
            br.redirect_pc = 32'd0;
        end
    end

    // Branch context, comparator operands and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_r      <= 3'd0;
            pc_r          <= 32'd0;
            imm_r         <= 32'd0;
            pred_r        <= 1'b0;
            cmp_a_r       <= 32'd0;
            cmp_b_r       <= 32'd0;
            br_cnt_r      <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (accept_s) begin
                funct3_r <= br.br_funct3;
                pc_r     <= br.br_pc;
                imm_r    <= br.br_imm;
                pred_r   <= br.br_pred;
            end
            if (opnd_load_s) begin
                cmp_a_r <= rs1_val;
                cmp_b_r <= rs2_val;
            end
            if (active_s) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (br.redirect_valid) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    branch_bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (active_s && !illegal_s),
        .wr_idx   (pc_r[IDX_W+1:2]),
        .wr_taken (taken_s)
    );

    assign if_pred_taken = rd_ctr_s[1];

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, hand-written
// corner sequences and randomized branches against a behavioural model.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] rs1_val, rs2_val;
    logic        opnd_hazard, kill;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_neq, cmp_lt;
    logic [31:0] br_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state.
    int          bht_m [16];
    logic [31:0] br_cnt_m;
    logic [31:0] mis_m;

    branch_ctrl_if bif ();

    branch_ctrl #(.IDX_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .br            (bif.slave),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .opnd_hazard   (opnd_hazard),
        .kill          (kill),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .cmp_neq       (cmp_neq),
        .cmp_lt        (cmp_lt),
        .br_cnt        (br_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // Stand-in for the external branch_comparator.
    assign cmp_neq = (cmp_a != cmp_b);
    assign cmp_lt  = (cmp_a < cmp_b);

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic [31:0] a;
        logic [31:0] b;
        int          hz;
        logic        exp_taken;
        logic        exp_ill;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int bht_step(input int c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        else   return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        br_cnt_m = 32'd0;
        mis_m    = 32'd0;
    endtask

    // One branch from acceptance through resolution; entered and left in IDLE.
    task automatic run_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic [31:0] a, input logic [31:0] b,
                          input int hz, input bit kill_res,
                          input logic e_taken, input logic e_ill, input logic e_redir,
                          input logic [31:0] e_pc);
        int id;
        id = idx_of(pc);
        if_pc          = pc;
        bif.br_valid   = 1'b1;
        bif.br_funct3  = f3;
        bif.br_pc      = pc;
        bif.br_imm     = imm;
        bif.br_pred    = pred;
        rs1_val        = (hz > 0) ? $urandom : a;
        rs2_val        = (hz > 0) ? $urandom : b;
        opnd_hazard    = (hz > 0);
        kill           = 1'b0;
        #1 check("ready_accept", {31'd0, bif.br_ready}, 32'd1);
        @(posedge clk); #1;
        bif.br_valid  = 1'b0;
        bif.br_funct3 = 3'($urandom);
        bif.br_pc     = $urandom;
        bif.br_imm    = $urandom;
        for (int k = 1; k <= hz; k++) begin
            rs1_val     = (k == hz) ? a : $urandom;
            rs2_val     = (k == hz) ? b : $urandom;
            opnd_hazard = (k < hz);
            #1;
            check("ready_wait", {31'd0, bif.br_ready}, 32'd0);
            check("resv_wait",  {31'd0, bif.res_valid}, 32'd0);
            @(posedge clk); #1;
        end
        rs1_val     = $urandom;
        rs2_val     = $urandom;
        opnd_hazard = 1'b0;
        kill        = kill_res;
        if_pc       = pc;
        #1;
        check("res_valid", {31'd0, bif.res_valid}, {31'd0, !kill_res});
        check("ready_resolve", {31'd0, bif.br_ready}, 32'd0);
        check("pred_old", {31'd0, if_pred_taken}, {31'd0, bht_m[id] >= 2});
        if (kill_res) begin
            check("redir_killed", {31'd0, bif.redirect_valid}, 32'd0);
        end else begin
            check("res_taken", {31'd0, bif.res_taken}, {31'd0, e_taken});
            check("illegal", {31'd0, bif.illegal_br}, {31'd0, e_ill});
            check("redir_valid", {31'd0, bif.redirect_valid}, {31'd0, e_redir});
            check("redir_pc", bif.redirect_pc, e_pc);
            br_cnt_m = br_cnt_m + 32'd1;
            if (e_redir) mis_m = mis_m + 32'd1;
            if (!e_ill) bht_m[id] = bht_step(bht_m[id], e_taken);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        #1;
        check("ready_after", {31'd0, bif.br_ready}, 32'd1);
        check("br_cnt", br_cnt, br_cnt_m);
        check("mispred_cnt", mispred_cnt, mis_m);
        check("pred_new", {31'd0, if_pred_taken}, {31'd0, bht_m[id] >= 2});
    endtask

    task automatic run_model(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                             input logic pred, input logic [31:0] a, input logic [31:0] b,
                             input int hz, input bit kill_res);
        logic t, ill;
        t   = model_taken(f3, a, b);
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        run_br(f3, pc, imm, pred, a, b, hz, kill_res, t, ill, t != pred,
               t ? pc + imm : pc + 32'd4);
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'd5, 32'd5, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0120};
        vecs[1] = '{3'b100, 32'h0000_0204, 32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0244};
        vecs[2] = '{3'b110, 32'h0000_0208, 32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_020C};
        vecs[3] = '{3'b001, 32'h0000_030C, 32'hFFFF_FFF0, 1'b1, 32'd3, 32'd7, 3, 1'b1, 1'b0, 1'b0, 32'h0000_02FC};
        vecs[4] = '{3'b010, 32'h0000_0110, 32'h0000_0020, 1'b0, 32'd9, 32'd9, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0114};
        vecs[5] = '{3'b101, 32'h0000_0400, 32'h0000_0008, 1'b0, 32'h8000_0000, 32'd0, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0404};
        vecs[6] = '{3'b111, 32'h0000_0400, 32'h0000_0008, 1'b1, 32'h8000_0000, 32'd0, 2, 1'b1, 1'b0, 1'b0, 32'h0000_0408};
        vecs[7] = '{3'b011, 32'h0000_000C, 32'h0000_0100, 1'b1, 32'd1, 32'd2, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
        vecs[8] = '{3'b000, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 32'd1, 32'd1, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};

        rst = 1'b1; if_pc = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        opnd_hazard = 1'b0; kill = 1'b0;
        bif.br_valid = 1'b0; bif.br_funct3 = 3'd0; bif.br_pc = 32'd0;
        bif.br_imm = 32'd0; bif.br_pred = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, bif.br_ready}, 32'd1);
        check("rst_resv", {31'd0, bif.res_valid}, 32'd0);
        check("rst_redir_pc", bif.redirect_pc, 32'd0);
        check("rst_cmp_a", cmp_a, 32'd0);
        check("rst_cmp_b", cmp_b, 32'd0);
        check("rst_br_cnt", br_cnt, 32'd0);
        check("rst_mispred", mispred_cnt, 32'd0);
        check("rst_pred", {31'd0, if_pred_taken}, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_br(vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].pred, vecs[i].a, vecs[i].b,
                   vecs[i].hz, 1'b0, vecs[i].exp_taken, vecs[i].exp_ill, vecs[i].exp_redir,
                   vecs[i].exp_pc);
        end
        check("bht0_after_beq", {30'd0, dut.u_bht.ctr_r[0]}, 32'd2);

        // Saturation at index 7, then one not-taken.
        for (int i = 0; i < 4; i++) begin
            run_br(3'b101, 32'h0000_051C, 32'h0000_0010, 1'b1, 32'd5, 32'd3, 0, 1'b0,
                   1'b1, 1'b0, 1'b0, 32'h0000_052C);
        end
        check("bht7_sat", bht_m[7], 32'd3);
        run_br(3'b101, 32'h0000_051C, 32'h0000_0010, 1'b1, 32'd1, 32'd3, 0, 1'b0,
               1'b0, 1'b0, 1'b1, 32'h0000_0520);
        check("bht7_pred_after_nt", {31'd0, if_pred_taken}, 32'd1);

        // Kill in RESOLVE.
        run_model(3'b000, 32'h0000_0518, 32'h0000_0004, 1'b0, 32'd2, 32'd2, 0, 1'b1);

        // Kill in IDLE blocks acceptance.
        bif.br_valid = 1'b1; bif.br_funct3 = 3'b000; bif.br_pc = 32'h0000_0600;
        kill = 1'b1;
        #1 check("kill_idle_ready", {31'd0, bif.br_ready}, 32'd0);
        @(posedge clk); #1;
        bif.br_valid = 1'b0; kill = 1'b0;
        #1;
        check("kill_idle_no_res", {31'd0, bif.res_valid}, 32'd0);
        check("kill_idle_still_idle", {31'd0, bif.br_ready}, 32'd1);

        // Kill in WAIT returns to IDLE with nothing resolved.
        bif.br_valid = 1'b1; opnd_hazard = 1'b1;
        @(posedge clk); #1;
        bif.br_valid = 1'b0; kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; opnd_hazard = 1'b0;
        #1;
        check("kill_wait_idle", {31'd0, bif.br_ready}, 32'd1);
        check("kill_wait_no_res", {31'd0, bif.res_valid}, 32'd0);
        check("kill_wait_cnt", br_cnt, br_cnt_m);

        // Randomized branches against the model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b, pc;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            run_model(3'($urandom), pc, $urandom, 1'($urandom), a, b,
                      $urandom_range(0, 2), $urandom_range(0, 7) == 0);
        end

        // Reset in RESOLVE discards the branch and clears all state.
        if_pc = 32'h0000_051C;
        bif.br_valid = 1'b1; bif.br_funct3 = 3'b000; bif.br_pc = 32'h0000_0700;
        bif.br_imm = 32'd4; bif.br_pred = 1'b0; rs1_val = 32'd1; rs2_val = 32'd1;
        @(posedge clk); #1;
        bif.br_valid = 1'b0; rst = 1'b1;
        #1 check("rst_mid_no_res", {31'd0, bif.res_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_mid_cnt", br_cnt, br_cnt_m);
        check("rst_mid_mis", mispred_cnt, mis_m);
        check("rst_mid_bht", {31'd0, if_pred_taken}, 32'd0);
        check("rst_mid_ready", {31'd0, bif.br_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
